// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer: one cpu_en pulse per instruction,
// with free-run, multi-step and PC-breakpoint halt plus a retire counter.
module cpu_step_ctrl #(
    parameter int RUN_DIV = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic [7:0]       step_num,
    input  logic             brk_en,
    input  logic [31:0]      brk_addr,
    input  logic [31:0]      pc,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic             running,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_BRK  = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

    logic [1:0]  state, nxt_state;
    logic [15:0] div_cnt, nxt_div;
    logic [7:0]  remaining, nxt_rem;
    logic        skip, nxt_skip;
    logic        nxt_en;
    logic        btn_step_q, btn_run_q;
    logic        run_rise, step_rise;
    logic        bp, slot;
    logic [7:0]  step_load;

    assign run_rise  = btn_run & ~btn_run_q;
    assign step_rise = btn_step & ~btn_step_q & ~run_rise;
    assign bp        = brk_en & (pc == brk_addr) & ~skip;
    assign slot      = (div_cnt == DIV_LAST);
    assign step_load = (step_num == 8'd0) ? 8'd1 : step_num;

    always_comb begin
        nxt_state = state;
        nxt_en    = 1'b0;
        nxt_rem   = remaining;
        nxt_skip  = skip;
        nxt_div   = div_cnt;
        case (state)
            S_IDLE, S_BRK: begin
                if (run_rise) begin
                    nxt_state = S_RUN;
                    nxt_div   = 16'd0;
                    nxt_skip  = 1'b1;
                end else if (step_rise) begin
                    nxt_state = S_STEP;
                    nxt_rem   = step_load;
                    nxt_skip  = 1'b1;
                end
            end
            S_STEP: begin
                // A cycle with cpu_en high is the gap: pc is not yet updated.
                if (run_rise) begin
                    nxt_state = S_IDLE;
                end else if (cpu_en) begin
                    if (remaining == 8'd0)
                        nxt_state = S_IDLE;
                end else if (bp) begin
                    nxt_state = S_BRK;
                end else begin
                    nxt_en   = 1'b1;
                    nxt_rem  = remaining - 8'd1;
                    nxt_skip = 1'b0;
                end
            end
            S_RUN: begin
                if (run_rise) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_div = slot ? 16'd0 : div_cnt + 16'd1;
                    if (slot) begin
                        if (bp) begin
                            nxt_state = S_BRK;
                        end else begin
                            nxt_en   = 1'b1;
                            nxt_skip = 1'b0;
                        end
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cpu_en     <= 1'b0;
            running    <= 1'b0;
            brk_hit    <= 1'b0;
            remaining  <= 8'd0;
            div_cnt    <= 16'd0;
            skip       <= 1'b0;
            btn_step_q <= 1'b0;
            btn_run_q  <= 1'b0;
        end else begin
            state      <= nxt_state;
            cpu_en     <= nxt_en;
            running    <= (nxt_state == S_STEP) | (nxt_state == S_RUN);
            brk_hit    <= (nxt_state == S_BRK);
            remaining  <= nxt_rem;
            div_cnt    <= nxt_div;
            skip       <= nxt_skip;
            btn_step_q <= btn_step;
            btn_run_q  <= btn_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr_count <= '0;
        else if (clr_cnt)
            instr_count <= '0;
        else if (cpu_en)
            instr_count <= instr_count + 1'b1;
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed plan steps plus random button traffic,
// every cycle compared against a cycle-indexed behavioural model.
module tb_cpu_step_ctrl;

    localparam int RUN_DIV = 4;
    localparam int M_IDLE = 0, M_STEP = 1, M_RUN = 2, M_BRK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_step = 1'b0, btn_run = 1'b0;
    logic [7:0]  step_num = 8'd1;
    logic        brk_en = 1'b0;
    logic [31:0] brk_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        clr_cnt = 1'b0;
    logic        cpu_en, running, brk_hit;
    logic [31:0] instr_count;

    cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
        .step_num(step_num), .brk_en(brk_en), .brk_addr(brk_addr),
        .pc(pc), .clr_cnt(clr_cnt), .cpu_en(cpu_en), .running(running),
        .brk_hit(brk_hit), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int npulse = 0;

    // Model: mode, predicted cpu_en, remaining steps, skip, RUN entry cycle.
    int          m_mode, m_left, t, t0;
    logic        m_en, m_skip, p_step, p_run, adv;
    logic [31:0] m_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_en = 0; m_left = 0; m_skip = 0;
        p_step = 0; p_run = 0; m_cnt = 0; adv = 0; t = 0; t0 = 0;
        pc = 0;
    endtask

    task automatic model_step();
        logic rr, sr, bp, ne;
        int   ld;
        if (rst) begin m_reset(); return; end
        rr = btn_run & ~p_run;
        sr = btn_step & ~p_step & ~rr;
        bp = brk_en && (pc == brk_addr) && !m_skip;
        ld = (step_num == 0) ? 1 : int'(step_num);
        ne = 0;
        adv = m_en;
        if (clr_cnt) m_cnt = 0;
        else if (m_en) m_cnt = m_cnt + 1;
        if (m_mode == M_IDLE || m_mode == M_BRK) begin
            if (rr) begin m_mode = M_RUN; t0 = t + 1; m_skip = 1; end
            else if (sr) begin m_mode = M_STEP; m_left = ld; m_skip = 1; end
        end else if (m_mode == M_STEP) begin
            if (rr) m_mode = M_IDLE;
            else if (m_en) begin
                if (m_left == 0) m_mode = M_IDLE;
            end else if (bp) m_mode = M_BRK;
            else begin ne = 1; m_left--; m_skip = 0; end
        end else begin
            if (rr) m_mode = M_IDLE;
            else if ((t - t0) % RUN_DIV == RUN_DIV - 1) begin
                if (bp) m_mode = M_BRK;
                else begin ne = 1; m_skip = 0; end
            end
        end
        p_run = btn_run; p_step = btn_step;
        m_en = ne;
        t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (adv) pc = pc + 32'd4;
        if (cpu_en) npulse++;
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        chk("running", {31'd0, running},
            {31'd0, (m_mode == M_STEP || m_mode == M_RUN)});
        chk("brk_hit", {31'd0, brk_hit}, {31'd0, (m_mode == M_BRK)});
        chk("instr_count", instr_count, m_cnt);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1 m_reset();
        tick();
        #2 rst = 0;
    endtask

    task automatic press_step();
        btn_step = 1; tick(); btn_step = 0; tick();
    endtask

    task automatic press_run();
        btn_run = 1; tick(); btn_run = 0; tick();
    endtask

    initial begin
        int p0, p1;
        bit got;
        m_reset();
        do_reset();
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // 1: three-instruction step
        step_num = 8'd3; npulse = 0;
        press_step(); ticks(12);
        chk("step3_pulses", npulse, 32'd3);
        chk("step3_count", instr_count, 32'd3);
        chk("step3_running", {31'd0, running}, 32'd0);

        // 2: step_num 0 acts as 1; a held button steps once
        step_num = 8'd0; npulse = 0;
        press_step(); ticks(6);
        chk("step0_pulses", npulse, 32'd1);
        npulse = 0; btn_step = 1; ticks(100); btn_step = 0; ticks(4);
        chk("hold_pulses", npulse, 32'd1);

        // 3: free run then halt
        npulse = 0;
        press_run(); ticks(38);
        btn_run = 1; tick(); btn_run = 0;
        p0 = npulse; tick(); p1 = npulse; ticks(10);
        chk("halt_late_pulses", npulse - p1, 32'd0);
        chk("run_pulses_ok", {31'd0, (p0 >= 9 && p0 <= 11)}, 32'd1);

        // 5: simultaneous run/step rise enters RUN
        step_num = 8'd1;
        btn_run = 1; btn_step = 1; tick(); btn_run = 0; btn_step = 0;
        ticks(20);
        chk("both_rise_running", {31'd0, running}, 32'd1);
        press_run(); ticks(4);

        // 4: breakpoint at 0x10, then step off it
        do_reset();
        brk_en = 1; brk_addr = 32'h10;
        press_run(); ticks(30);
        chk("brk_hit", {31'd0, brk_hit}, 32'd1);
        chk("brk_count", instr_count, 32'd4);
        chk("brk_pc", pc, 32'h10);
        step_num = 8'd1;
        press_step(); ticks(8);
        chk("brk_step_count", instr_count, 32'd5);
        chk("brk_step_pc", pc, 32'h14);
        chk("brk_step_idle", {31'd0, running | brk_hit}, 32'd0);
        brk_en = 0;

        // 6: async reset mid-run, then clear during a pulse
        press_run(); ticks(10);
        #3 rst = 1;
        #1;
        chk("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("arst_running", {31'd0, running}, 32'd0);
        chk("arst_count", instr_count, 32'd0);
        m_reset(); tick(); #2 rst = 0;
        press_run();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_en) begin
                clr_cnt = 1; tick(); clr_cnt = 0; got = 1;
                chk("clr_with_en", instr_count, 32'd0);
            end else tick();
        end
        chk("clr_reached", {31'd0, got}, 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 31) == 0) step_num = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 63) == 0) brk_en = ~brk_en;
            if ($urandom_range(0, 15) == 0)
                brk_addr = pc + 32'(4 * $urandom_range(0, 6));
            clr_cnt = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
